// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: serializes parallel bitstream words MSB-first onto the
// fabric configuration chain (ccff_head) and gates prog_clk via ccff_shift_en.
// Optional chain self-test: define CCFF_CHAIN_TEST_EN to add test_start and the
// TEST state that walks a single 1 through the chain and checks ccff_tail.
module ccff_bitstream_loader #(
   parameter int unsigned CHAIN_LEN = 1024,
   parameter int unsigned WORD_W    = 32,
   parameter int unsigned CNT_W     = 16
) (
   input  logic              prog_clk,
   input  logic              prog_reset,
   input  logic              start,
`ifdef CCFF_CHAIN_TEST_EN
   input  logic              test_start,
`endif
   input  logic [WORD_W-1:0] word_data,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [CNT_W-1:0]  bits_sent
);

   localparam int unsigned      WC_W    = $clog2(WORD_W + 1);
   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(CHAIN_LEN - 1);
   localparam logic [WC_W-1:0]  LP_WLAST = WC_W'(WORD_W - 1);
`ifdef CCFF_CHAIN_TEST_EN
   localparam logic [CNT_W-1:0] LP_TAIL1 = CNT_W'(CHAIN_LEN);
   localparam logic [CNT_W-1:0] LP_TAIL0 = CNT_W'(CHAIN_LEN + 1);
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
`ifdef CCFF_CHAIN_TEST_EN
      S_TEST,
`endif
      S_FIN
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [WORD_W-1:0]  r_sreg, w_sreg_nxt;
   logic [WC_W-1:0]    r_wcnt, w_wcnt_nxt;
   logic [CNT_W-1:0]   r_bits, w_bits_nxt;
   logic               r_ready;
   logic               r_head, w_head_nxt;
   logic               r_shen, w_shen_nxt;
   logic               r_busy;
   logic               r_done;
`ifdef CCFF_CHAIN_TEST_EN
   logic               r_error, w_error_nxt;
`else
   logic               w_unused_tail;
`endif

   // Next-state, datapath and next-output decode; head/shift_en are computed
   // for the upcoming cycle so the outputs themselves come straight from flops.
   always_comb begin
      w_state_nxt = r_state;
      w_sreg_nxt  = r_sreg;
      w_wcnt_nxt  = r_wcnt;
      w_bits_nxt  = r_bits;
      w_head_nxt  = 1'b0;
      w_shen_nxt  = 1'b0;
`ifdef CCFF_CHAIN_TEST_EN
      w_error_nxt = r_error;
`endif
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_LOAD;
               w_bits_nxt  = '0;
`ifdef CCFF_CHAIN_TEST_EN
               w_error_nxt = 1'b0;
`endif
            end
`ifdef CCFF_CHAIN_TEST_EN
            else if (test_start) begin
               // a test run also clears the sticky error so each run reports on its own
               w_state_nxt = S_TEST;
               w_bits_nxt  = '0;
               w_error_nxt = 1'b0;
               w_head_nxt  = 1'b1;
               w_shen_nxt  = 1'b1;
            end
`endif
         end
         S_LOAD: begin
            if (word_valid && r_ready) begin
               w_state_nxt = S_SHIFT;
               w_sreg_nxt  = word_data;
               w_wcnt_nxt  = '0;
               w_head_nxt  = word_data[WORD_W-1];
               w_shen_nxt  = 1'b1;
            end
         end
         S_SHIFT: begin
            w_sreg_nxt = r_sreg << 1;
            w_bits_nxt = r_bits + 1'b1;
            w_wcnt_nxt = r_wcnt + 1'b1;
            if (r_bits == LP_LAST) begin
               w_state_nxt = S_FIN;
            end else if (r_wcnt == LP_WLAST) begin
               w_state_nxt = S_LOAD;
            end else begin
               w_head_nxt = w_sreg_nxt[WORD_W-1];
               w_shen_nxt = 1'b1;
            end
         end
`ifdef CCFF_CHAIN_TEST_EN
         S_TEST: begin
            w_bits_nxt = r_bits + 1'b1;
            if ((r_bits == LP_TAIL1) && !ccff_tail) w_error_nxt = 1'b1;
            if ((r_bits == LP_TAIL0) &&  ccff_tail) w_error_nxt = 1'b1;
            if (r_bits == LP_TAIL0) begin
               w_state_nxt = S_FIN;
            end else begin
               w_shen_nxt = 1'b1;
            end
         end
`endif
         S_FIN: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State, datapath and registered outputs.
   always_ff @(posedge prog_clk or posedge prog_reset) begin
      if (prog_reset) begin
         r_state <= S_IDLE;
         r_sreg  <= '0;
         r_wcnt  <= '0;
         r_bits  <= '0;
         r_ready <= 1'b0;
         r_head  <= 1'b0;
         r_shen  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_sreg  <= w_sreg_nxt;
         r_wcnt  <= w_wcnt_nxt;
         r_bits  <= w_bits_nxt;
         r_ready <= (w_state_nxt == S_LOAD);
         r_head  <= w_head_nxt;
         r_shen  <= w_shen_nxt;
`ifdef CCFF_CHAIN_TEST_EN
         r_busy  <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_SHIFT) ||
                    (w_state_nxt == S_TEST);
`else
         r_busy  <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_SHIFT);
`endif
         r_done  <= (w_state_nxt == S_FIN);
      end
   end

`ifdef CCFF_CHAIN_TEST_EN
   // Sticky chain-test error flag.
   always_ff @(posedge prog_clk or posedge prog_reset) begin
      if (prog_reset) r_error <= 1'b0;
      else            r_error <= w_error_nxt;
   end
   assign error = r_error;
`else
   assign w_unused_tail = ccff_tail;
   assign error         = 1'b0;
`endif

   assign word_ready    = r_ready;
   assign ccff_head     = r_head;
   assign ccff_shift_en = r_shen;
   assign busy          = r_busy;
   assign done          = r_done;
   assign bits_sent     = r_bits;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: instance A (CHAIN_LEN=8, WORD_W=4) with an
// 8-flop model chain, instance B (CHAIN_LEN=6, WORD_W=4). Chain-test checks are
// compiled when CCFF_CHAIN_TEST_EN is defined.
module tb_ccff_bitstream_loader;

   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // instance A
   logic       a_start, a_valid, a_ready, a_head, a_shen, a_tail, a_busy, a_done, a_error;
   logic [3:0] a_data;
   logic [7:0] a_bits;
`ifdef CCFF_CHAIN_TEST_EN
   logic       a_tstart;
`endif
   // instance B
   logic       b_start, b_valid, b_ready, b_head, b_shen, b_busy, b_done, b_error;
   logic [3:0] b_data;
   logic [7:0] b_bits;
`ifdef CCFF_CHAIN_TEST_EN
   logic       b_tstart;
`endif

   ccff_bitstream_loader #(.CHAIN_LEN(8), .WORD_W(4), .CNT_W(8)) u_a (
      .prog_clk(clk), .prog_reset(rst), .start(a_start),
`ifdef CCFF_CHAIN_TEST_EN
      .test_start(a_tstart),
`endif
      .word_data(a_data), .word_valid(a_valid), .word_ready(a_ready),
      .ccff_head(a_head), .ccff_shift_en(a_shen), .ccff_tail(a_tail),
      .busy(a_busy), .done(a_done), .error(a_error), .bits_sent(a_bits)
   );

   ccff_bitstream_loader #(.CHAIN_LEN(6), .WORD_W(4), .CNT_W(8)) u_b (
      .prog_clk(clk), .prog_reset(rst), .start(b_start),
`ifdef CCFF_CHAIN_TEST_EN
      .test_start(b_tstart),
`endif
      .word_data(b_data), .word_valid(b_valid), .word_ready(b_ready),
      .ccff_head(b_head), .ccff_shift_en(b_shen), .ccff_tail(1'b0),
      .busy(b_busy), .done(b_done), .error(b_error), .bits_sent(b_bits)
   );

   // 8-flop model chain on instance A, optionally with its tail stuck at 0
   logic [7:0] chain = '0;
   logic       stuck = 1'b0;
   always @(posedge clk) if (a_shen) chain <= {chain[6:0], a_head};
   assign a_tail = stuck ? 1'b0 : chain[7];

   // monitors sample mid-cycle: accepted words and shifted head bits
   int a_words = 0, b_words = 0;
   bit a_heads[$];
   bit b_heads[$];
   always @(negedge clk) begin
      if (a_valid && a_ready) a_words <= a_words + 1;
      if (b_valid && b_ready) b_words <= b_words + 1;
      if (a_shen) a_heads.push_back(a_head);
      if (b_shen) b_heads.push_back(b_head);
   end

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic heads_a(input int from, output logic [31:0] v, output int n);
      v = '0; n = 0;
      for (int i = from; i < a_heads.size(); i++) begin
         v = {v[30:0], a_heads[i]};
         n++;
      end
   endtask

   task automatic start_a();
      a_start = 1'b1; tick(); a_start = 1'b0;
   endtask

   // offer w0 then w1 with valid high until done or budget; optional start pulses mid-load
   task automatic feed_a(input logic [3:0] w0, input logic [3:0] w1, input int budget,
                         input bit inj, output bit got_done);
      int base;
      base = a_words;
      got_done = 1'b0;
      for (int c = 0; c < budget && !got_done; c++) begin
         a_valid = 1'b1;
         a_data  = (a_words == base) ? w0 : w1;
         a_start = inj && (c == 2 || c == 5);
         tick();
         if (a_done) got_done = 1'b1;
      end
      a_valid = 1'b0;
      a_start = 1'b0;
   endtask

   typedef struct {
      logic       start, valid;
      logic [3:0] data;
      logic       e_ready, e_head, e_shen, e_busy, e_done;
      logic [7:0] e_bits;
   } vec_t;

   function automatic vec_t mk(input logic s, input logic v, input logic [3:0] d,
                               input logic r, input logic h, input logic e,
                               input logic b, input logic dn, input logic [7:0] n);
      vec_t t;
      t.start = s; t.valid = v; t.data = d;
      t.e_ready = r; t.e_head = h; t.e_shen = e; t.e_busy = b; t.e_done = dn; t.e_bits = n;
      return t;
   endfunction

   vec_t        tbl[12];
   logic [31:0] hv;
   int          hn, snap, wsnap, bad;
   bit          got;
`ifdef CCFF_CHAIN_TEST_EN
   logic        tail8, tail9;
`endif

   initial begin
      //          start valid data  ready head shen busy done bits
      tbl[0]  = mk(H, H, 4'hA,  H, L, L, H, L, 8'd0);
      tbl[1]  = mk(L, H, 4'hA,  L, H, H, H, L, 8'd0);
      tbl[2]  = mk(L, H, 4'hA,  L, L, H, H, L, 8'd1);
      tbl[3]  = mk(L, H, 4'hA,  L, H, H, H, L, 8'd2);
      tbl[4]  = mk(L, H, 4'hA,  L, L, H, H, L, 8'd3);
      tbl[5]  = mk(L, H, 4'h5,  H, L, L, H, L, 8'd4);
      tbl[6]  = mk(L, H, 4'h5,  L, L, H, H, L, 8'd4);
      tbl[7]  = mk(L, H, 4'h5,  L, H, H, H, L, 8'd5);
      tbl[8]  = mk(L, H, 4'h5,  L, L, H, H, L, 8'd6);
      tbl[9]  = mk(L, H, 4'h5,  L, H, H, H, L, 8'd7);
      tbl[10] = mk(L, H, 4'h5,  L, L, L, L, H, 8'd8);
      tbl[11] = mk(L, L, 4'h5,  L, L, L, L, L, 8'd8);

      rst = 1'b1;
      a_start = 1'b0; a_valid = 1'b0; a_data = '0;
      b_start = 1'b0; b_valid = 1'b0; b_data = '0;
`ifdef CCFF_CHAIN_TEST_EN
      a_tstart = 1'b0; b_tstart = 1'b0;
`endif
      repeat (2) tick();
      chk("reset_a", {a_ready, a_head, a_shen, a_busy, a_done, a_error, a_bits}, '0);
      chk("reset_b", {b_ready, b_head, b_shen, b_busy, b_done, b_error, b_bits}, '0);
      rst = 1'b0;
      tick();

      // plan 1: cycle-by-cycle load of 0xA, 0x5
      wsnap = a_words;
      snap  = a_heads.size();
      for (int i = 0; i < 12; i++) begin
         a_start = tbl[i].start; a_valid = tbl[i].valid; a_data = tbl[i].data;
         tick();
         chk($sformatf("vec%0d", i),
             {a_ready, a_head, a_shen, a_busy, a_done, a_bits},
             {tbl[i].e_ready, tbl[i].e_head, tbl[i].e_shen, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_bits});
      end
      a_valid = 1'b0; a_start = 1'b0;
      heads_a(snap, hv, hn);
      chk("p1_heads", hv, 32'hA5);
      chk("p1_words", a_words - wsnap, 2);

      // plan 2: CHAIN_LEN=6 truncates the second word
      b_start = 1'b1; tick(); b_start = 1'b0;
      wsnap = b_words; snap = b_heads.size(); got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
         b_valid = 1'b1;
         b_data  = (b_words == wsnap) ? 4'hF : 4'hC;
         tick();
         if (b_done) got = 1'b1;
      end
      b_valid = 1'b0;
      chk("p2_done", got, 1);
      chk("p2_shifts", b_heads.size() - snap, 6);
      hv = '0;
      for (int i = snap; i < b_heads.size(); i++) hv = {hv[30:0], b_heads[i]};
      chk("p2_heads", hv, 32'h3F);
      chk("p2_words", b_words - wsnap, 2);
      chk("p2_bits", b_bits, 6);

      // plan 3: stall 20 cycles in LOAD between the two words
      tick();
      start_a();
      snap = a_heads.size();
      a_valid = 1'b1; a_data = 4'hA; tick(); a_valid = 1'b0;
      repeat (4) tick();
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (!(a_ready === 1'b1 && a_shen === 1'b0 && a_bits === 8'd4)) bad++;
      end
      chk("p3_stall", bad, 0);
      feed_a(4'h5, 4'h5, 40, 1'b0, got);
      chk("p3_done", got, 1);
      heads_a(snap, hv, hn);
      chk("p3_heads", hv, 32'hA5);
      chk("p3_nshift", hn, 8);
      chk("p3_bits", a_bits, 8);
      tick();
      chk("p3_idle", {a_busy, a_done}, 2'b00);

      // plan 4: reset during the second word, then reload from scratch
      start_a();
      feed_a(4'hA, 4'h5, 8, 1'b0, got);
      chk("p4_mid", {got, a_shen, a_bits}, {1'b0, 1'b1, 8'd6});
      rst = 1'b1;
      #1;
      chk("p4_async", {a_ready, a_head, a_shen, a_busy, a_done, a_error, a_bits}, '0);
      tick();
      rst = 1'b0;
      tick();
      start_a();
      chk("p4_restart", {a_busy, a_bits}, {1'b1, 8'd0});
      snap = a_heads.size();
      feed_a(4'hA, 4'h5, 40, 1'b0, got);
      chk("p4_done", got, 1);
      heads_a(snap, hv, hn);
      chk("p4_heads", hv, 32'hA5);
      chk("p4_bits", a_bits, 8);
      tick();

      // plan 6: start pulses while busy are ignored
      start_a();
      wsnap = a_words; snap = a_heads.size();
      feed_a(4'hA, 4'h5, 40, 1'b1, got);
      chk("p6_done", got, 1);
      chk("p6_words", a_words - wsnap, 2);
      heads_a(snap, hv, hn);
      chk("p6_heads", hv, 32'hA5);
      chk("p6_bits", a_bits, 8);
      tick();
      chk("p6_idle", {a_busy, a_done, a_ready}, 3'b000);

`ifdef CCFF_CHAIN_TEST_EN
      // plan 5: chain test, healthy chain
      snap = a_heads.size();
      a_tstart = 1'b1; tick(); a_tstart = 1'b0;
      got = 1'b0; bad = 0; tail8 = 1'bx; tail9 = 1'bx;
      for (int c = 0; c < 30 && !got; c++) begin
         if (a_ready) bad++;
         if (a_shen && a_bits == 8'd8) tail8 = a_tail;
         if (a_shen && a_bits == 8'd9) tail9 = a_tail;
         tick();
         if (a_done) got = 1'b1;
      end
      chk("p5_done", got, 1);
      chk("p5_tail8", tail8, 1);
      chk("p5_tail9", tail9, 0);
      chk("p5_error", a_error, 0);
      chk("p5_ready", bad, 0);
      heads_a(snap, hv, hn);
      chk("p5_nshift", hn, 10);
      chk("p5_heads", hv, 32'h200);
      tick();

      // plan 5: tail stuck at 0
      stuck = 1'b1;
      a_tstart = 1'b1; tick(); a_tstart = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 30 && !got; c++) begin
         tick();
         if (a_done) got = 1'b1;
      end
      stuck = 1'b0;
      chk("p5s_done", got, 1);
      chk("p5s_error", a_error, 1);
      tick();
      chk("p5s_sticky", a_error, 1);

      // start beats test_start; accepted start clears error
      a_start = 1'b1; a_tstart = 1'b1; tick(); a_start = 1'b0; a_tstart = 1'b0;
      chk("p5_startwins", {a_ready, a_shen, a_error}, 3'b100);
      rst = 1'b1; tick(); rst = 1'b0; tick();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
On-chip transmitter for the FPGA configuration chain. It accepts parallel bitstream words from the management side over a valid/ready handshake and serializes them MSB-first onto ccff_head. It also drives a shift enable that gates prog_clk into the fabric, and monitors ccff_tail. It replaces external pin-driven chain loading. The block sits between the SoC-side register interface and the fabric's ccff_head/ccff_tail pins.

Parameters:
CHAIN_LEN, 1024, number of configuration flops in the chain (bits to shift).
WORD_W, 32, bitstream word width.
CNT_W, 16, width of the bit counter; must satisfy 2^CNT_W > CHAIN_LEN+1.

Ports:
prog_clk  input  1  programming clock; all state is clocked on posedge.
prog_reset  input  1  asynchronous, active-high reset.
start  input  1  one-cycle pulse; begins a load when IDLE.
word_data  input  WORD_W  bitstream word; bit WORD_W-1 is shifted first.
word_valid  input  1  word_data is valid.
word_ready  output  1  loader accepts a word this cycle.
ccff_head  output  1  serial data to the chain head.
ccff_shift_en  output  1  fabric captures ccff_head on the next prog_clk posedge.
ccff_tail  input  1  chain tail, sampled in prog_clk domain.
busy  output  1  high from the cycle after an accepted start until done.
done  output  1  one-cycle pulse when the operation completes.
error  output  1  sticky chain-test failure; cleared by next accepted start.
bits_sent  output  CNT_W  number of shifts completed in the current operation.

Behaviour:
- Reset values (async, immediate): state=IDLE, word_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, done=0, error=0, bits_sent=0, shift register=0.
- All outputs are registered.
- FSM states: IDLE, LOAD, SHIFT, FIN, plus TEST when the optional feature is compiled in.
- IDLE:
  - start=1 -> LOAD next cycle; busy=1, bits_sent=0, error=0.
  - start while not IDLE is ignored.
- LOAD:
  - word_ready=1, ccff_shift_en=0.
  - word_valid&&word_ready at posedge -> sreg<=word_data, word_cnt=0, go SHIFT.
  - No valid word: stay in LOAD indefinitely (stall); the chain holds because shift_en=0.
- SHIFT:
  - ccff_head=sreg[WORD_W-1], ccff_shift_en=1, word_ready=0.
  - Each posedge: sreg<<=1, bits_sent+=1, word_cnt+=1.
  - If bits_sent reaches CHAIN_LEN -> FIN. Remaining bits of the last word are discarded.
  - Else if word_cnt reaches WORD_W -> LOAD.
  - Result: exactly one bubble cycle (shift_en=0) per word boundary.
  - Words consumed = ceil(CHAIN_LEN/WORD_W).
- FIN:
  - shift_en=0, ccff_head=0, done=1 for one cycle, busy=0, then IDLE.
  - bits_sent holds its final value until the next start.
- Load mode never checks ccff_tail; error is unaffected.
- Reset mid-operation: immediate return to reset values; partial chain contents are not defined.
- ccff_head is only meaningful while ccff_shift_en=1; it is driven 0 otherwise.

Optional Feature:
Macro: CCFF_CHAIN_TEST_EN.
- Enabled: adds input test_start (1-bit pulse) and state TEST, entered from IDLE on test_start.
  - start and test_start in the same cycle: start wins.
  - In TEST, ccff_shift_en=1 for CHAIN_LEN+2 consecutive cycles.
  - ccff_head=1 only on the first shift, 0 thereafter.
  - ccff_tail is sampled in the cycle where bits_sent==CHAIN_LEN and must be 1. It is sampled again at bits_sent==CHAIN_LEN+1 and must be 0.
  - Any mismatch sets error (sticky).
  - After CHAIN_LEN+2 shifts -> FIN (done pulse).
  - word_ready stays 0 throughout TEST.
- Disabled: no test_start port, no TEST state, error is tied to 0.

Test Plan:
1. CHAIN_LEN=8, WORD_W=4: start, words 0xA then 0x5 offered with valid always high. Expect head sequence 1,0,1,0,0,1,0,1 on shift_en=1 cycles, one bubble between words, done pulse, bits_sent=8, busy low after done.
2. CHAIN_LEN=6, WORD_W=4: words 0xF, 0xC. Expect 6 shifts 1,1,1,1,1,1, then FIN; the last 2 bits of 0xC are discarded; exactly 2 words are accepted.
3. Stall: withhold word_valid for 20 cycles in LOAD. Expect word_ready=1, shift_en=0 and bits_sent frozen for those cycles, then normal resumption.
4. Assert prog_reset in the middle of the 2nd word. Expect all outputs 0 immediately; a subsequent start reloads from bits_sent=0.
5. CCFF_CHAIN_TEST_EN, CHAIN_LEN=8, ccff_tail from an 8-flop model chain: test_start. Expect tail=1 at bits_sent=8, 0 at 9, error=0, done after 10 shifts. Repeat with the model tail stuck at 0: error=1.
6. start pulse while busy=1. Expect it ignored; the current load completes with an unchanged word count.
